fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding, default parameter values and clog2.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAXBURST = 8;

  // Ceiling log2 with a floor of 1 so index vectors are never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bus of the write arbiter.
// slave = arbiter view, master = requesters plus FIFO view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);
  localparam int GW = clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      wdata;
  logic                  wpush;
  logic                  wfull;
  logic [GW-1:0]         gnt_id;
  logic                  busy;
  logic                  forced_rel;

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wdata, wpush, gnt_id, busy, forced_rel
  );

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wdata, wpush, gnt_id, busy, forced_rel
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular first-one search: lowest set bit of req at or
// after rr_ptr, wrapping past NREQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   rr_ptr,
  output logic [GW-1:0]   idx,
  output logic            found
);
  localparam int SW = GW + 1;

  logic [SW-1:0] sum_s;
  logic [GW-1:0] cand_s;

  // rr_ptr is always below NREQ, so a single conditional subtract wraps.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, rr_ptr} + SW'(k);
      if (sum_s >= SW'(NREQ)) begin
        cand_s = GW'(sum_s - SW'(NREQ));
      end else begin
        cand_s = GW'(sum_s);
      end
      if (!found && req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NREQ packet sources share one FIFO write
// port, holding each grant until last, or until MAXBURST beats have gone.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREQ     = DEF_NREQ,
  parameter int MAXBURST = DEF_MAXBURST
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = clog2(NREQ);
  localparam int CW = clog2(MAXBURST + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          forced_rel_q, forced_rel_d;

  logic [GW-1:0]    pick_idx_s;
  logic             pick_found_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [WIDTH-1:0] wdata_s;
  logic             wpush_s;
  logic             owner_last_s;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx_s),
    .found  (pick_found_s)
  );

  // Next-state and bus outputs; a release happens on last or on the beat
  // that brings the count to MAXBURST (cnt_q still holds the old count).
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    cnt_d        = cnt_q;
    forced_rel_d = 1'b0;
    req_ready_s  = '0;
    wdata_s      = '0;
    wpush_s      = 1'b0;
    owner_last_s = bus.req_last[gnt_id_q];
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d  = GRANT;
          gnt_id_d = pick_idx_s;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        req_ready_s[gnt_id_q] = ~bus.wfull;
        wdata_s = bus.req_data[int'(gnt_id_q) * WIDTH +: WIDTH];
        wpush_s = bus.req_valid[gnt_id_q] & ~bus.wfull;
        if (wpush_s) begin
          if (owner_last_s || (cnt_q == CW'(MAXBURST - 1))) begin
            state_d      = IDLE;
            cnt_d        = '0;
            forced_rel_d = ~owner_last_s;
            if (gnt_id_q == GW'(NREQ - 1)) begin
              rr_ptr_d = '0;
            end else begin
              rr_ptr_d = gnt_id_q + GW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      cnt_q        <= '0;
      forced_rel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      forced_rel_q <= forced_rel_d;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.wdata      = wdata_s;
  assign bus.wpush      = wpush_s;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.busy       = (state_q == GRANT);
  assign bus.forced_rel = forced_rel_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus();
  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAXBURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port, how many beats so far, where the
  // next search starts, and whether a forced release just happened.
  bit m_owned;
  int m_owner, m_ptr, m_beats;
  bit m_frel;

  // Sources: packet length (0 = never last), position, sequence, beats left.
  int src_len[N], src_pos[N], src_seq[N], src_budget[N];
  logic [W-1:0] src_base[N];
  bit gap[N];
  bit wfull_drv;

  int cyc;
  bit lg_busy[64], lg_push[64], lg_frel[64];
  int lg_gnt[64], lg_rdy[64];
  logic [W-1:0] lg_data[64];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit src_last(input int i);
    return (src_len[i] != 0) && (src_pos[i] == src_len[i] - 1);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = (src_budget[i] > 0) && !gap[i];
      bus.req_data[i*W +: W]   = src_base[i] + W'(src_seq[i]);
      bus.req_last[i]          = src_last(i);
    end
    bus.wfull = wfull_drv;
  endtask

  // Compare outputs with the model, then advance model and sources at the edge.
  task automatic tick();
    bit exp_push, lastv, found;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_data;
    exp_push = m_owned && bus.req_valid[m_owner] && !wfull_drv;
    exp_rdy  = (m_owned && !wfull_drv) ? (N'(1) << m_owner) : '0;
    exp_data = m_owned ? (src_base[m_owner] + W'(src_seq[m_owner])) : '0;
    lastv    = src_last(m_owner);
    chk("busy", bus.busy, m_owned);
    chk("gnt_id", bus.gnt_id, m_owner);
    chk("wpush", bus.wpush, exp_push);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("wdata", bus.wdata, exp_data);
    chk("forced_rel", bus.forced_rel, m_frel);
    if (cyc < 64) begin
      lg_busy[cyc] = bus.busy;
      lg_push[cyc] = bus.wpush;
      lg_frel[cyc] = bus.forced_rel;
      lg_gnt[cyc]  = int'(bus.gnt_id);
      lg_rdy[cyc]  = int'(bus.req_ready);
      lg_data[cyc] = bus.wdata;
    end
    cyc++;
    @(posedge clk);
    if (exp_push) begin
      src_seq[m_owner]++;
      src_budget[m_owner]--;
      src_pos[m_owner] = lastv ? 0 : src_pos[m_owner] + 1;
    end
    if (rst) begin
      m_owned = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_frel = 0;
    end else begin
      m_frel = 0;
      if (!m_owned) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && bus.req_valid[j]) begin
            found = 1;
            m_owner = j;
          end
        end
        m_owned = found;
      end else if (exp_push) begin
        m_beats++;
        if (lastv || m_beats == MB) begin
          m_frel  = !lastv;
          m_owned = 0;
          m_ptr   = (m_owner + 1) % N;
          m_beats = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    drive();
    #1;
    tick();
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_pos[i] = 0; src_seq[i] = 0; src_budget[i] = 0;
      src_base[i] = W'(32'h1000 * (i + 1));
      gap[i] = 0;
    end
    wfull_drv = 0;
  endtask

  task automatic do_reset();
    clear_srcs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    clear_srcs();
    drive();
    m_owned = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_frel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_wpush", bus.wpush, 1'b0);
    chk("reset_ready", bus.req_ready, 4'h0);
    chk("reset_wdata", bus.wdata, 32'h0);
    chk("reset_gnt", bus.gnt_id, 2'd0);
    chk("reset_frel", bus.forced_rel, 1'b0);
    @(negedge clk);
    do_reset();

    // Single requester, three-beat packet.
    src_base[2] = 32'hA1; src_len[2] = 3; src_budget[2] = 3;
    repeat (6) step();
    chk("single_idle0", lg_busy[0], 1'b0);
    chk("single_gnt", lg_gnt[1], 2);
    for (int c = 1; c <= 3; c++) begin
      chk("single_push", lg_push[c], 1'b1);
      chk("single_data", lg_data[c], 32'hA0 + c);
    end
    chk("single_done_busy", lg_busy[4], 1'b0);
    chk("single_done_push", lg_push[4], 1'b0);

    // Fairness with every requester sending one-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_budget[i] = 3;
    end
    repeat (10) step();
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        chk("fair_idle", lg_busy[2*g], 1'b0);
        chk("fair_gnt", lg_gnt[2*g+1], order[g]);
      end
    end

    // Forced release at MAXBURST while another requester waits.
    do_reset();
    src_len[1] = 0; src_budget[1] = 12; src_base[1] = 32'h100;
    src_len[3] = 1; src_budget[3] = 1;  src_base[3] = 32'h300;
    repeat (20) step();
    n = 0;
    for (int c = 1; c <= 8; c++) if (lg_push[c] && lg_gnt[c] == 1) n++;
    chk("force_beats", n, 8);
    chk("force_pulse_pre", lg_frel[8], 1'b0);
    chk("force_pulse", lg_frel[9], 1'b1);
    chk("force_pulse_post", lg_frel[10], 1'b0);
    chk("force_next_gnt", lg_gnt[10], 3);
    chk("force_resume_gnt", lg_gnt[12], 1);
    chk("force_resume_data", lg_data[12], 32'h108);
    n = 0;
    for (int c = 0; c < 20; c++) if (lg_push[c]) n++;
    chk("force_total", n, 13);
    chk("force_hold_busy", lg_busy[19], 1'b1);
    chk("force_hold_push", lg_push[19], 1'b0);

    // Backpressure mid-burst; the stall must not advance the beat count.
    do_reset();
    src_len[0] = 0; src_budget[0] = 10; src_base[0] = 32'h500;
    for (int c = 0; c < 20; c++) begin
      wfull_drv = (c >= 3 && c <= 7);
      step();
    end
    for (int c = 3; c <= 7; c++) begin
      chk("full_push", lg_push[c], 1'b0);
      chk("full_ready", lg_rdy[c], 0);
      chk("full_busy", lg_busy[c], 1'b1);
    end
    chk("full_frel", lg_frel[14], 1'b1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (lg_push[c]) begin
        chk("full_data", lg_data[c], 32'h500 + n);
        n++;
      end
    end
    chk("full_count", n, 10);

    // Reset in the middle of a burst clears the round-robin pointer too.
    do_reset();
    src_len[1] = 1; src_budget[1] = 1;
    src_len[2] = 4; src_budget[2] = 4;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_budget[i] = 2; src_pos[i] = 0;
    end
    repeat (2) step();
    chk("rst_pre_gnt", lg_gnt[3], 2);
    chk("rst_idle_busy", lg_busy[6], 1'b0);
    chk("rst_idle_push", lg_push[6], 1'b0);
    chk("rst_idle_gnt", lg_gnt[6], 0);
    chk("rst_win_gnt", lg_gnt[7], 0);
    chk("rst_win_busy", lg_busy[7], 1'b1);

    // Randomized traffic with gaps, backpressure and occasional reset.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_budget[i] == 0 && $urandom_range(0, 3) == 0) begin
          src_len[i]    = $urandom_range(0, 5);
          src_pos[i]    = 0;
          src_budget[i] = $urandom_range(1, 20);
          src_base[i]   = $urandom;
        end
        gap[i] = ($urandom_range(0, 9) == 0);
      end
      wfull_drv = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
